// File: rtl/whack_round_ctrl.sv
// Round sequencer for the ByteBasher whack-a-box game: target pick, lit window, hit/miss classification, game timer.
// Define HIT_STREAK_EN to add the consecutive-hit streak counter and its bonus pulse.
module whack_round_ctrl #(
    parameter int NUM_BOXES    = 6,
    parameter int SEC_DIV      = 50_000_000,
    parameter int GAME_SECONDS = 60,
    parameter int WIN_L1_CYC   = 100_000_000,
    parameter int WIN_L2_CYC   = 75_000_000,
    parameter int WIN_L3_CYC   = 50_000_000,
    parameter int SETTLE_CYC   = 1_000_000,
    parameter int PICK_TRIES   = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] lfsr_value,
    input  logic [2:0] sensor_input,
    output logic [2:0] target_box,
    output logic       target_valid,
    output logic       hit_detected,
    output logic       miss_pulse,
    output logic [5:0] game_timer,
    output logic [1:0] difficulty_level,
    output logic       busy,
    output logic       game_over
`ifdef HIT_STREAK_EN
    ,
    output logic [3:0] streak,
    output logic       streak_bonus
`endif
);

    localparam logic [2:0]  NB          = 3'(NUM_BOXES);
    localparam logic [2:0]  NO_HIT      = 3'b111;
    localparam logic [3:0]  TRIES       = 4'(PICK_TRIES);
    localparam logic [5:0]  GAME_END    = 6'(GAME_SECONDS);
    localparam logic [5:0]  LVL2_AT     = 6'(GAME_SECONDS / 3);
    localparam logic [5:0]  LVL3_AT     = 6'((2 * GAME_SECONDS) / 3);
    localparam logic [31:0] SEC_LAST    = 32'(SEC_DIV - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] WIN1        = 32'(WIN_L1_CYC);
    localparam logic [31:0] WIN2        = 32'(WIN_L2_CYC);
    localparam logic [31:0] WIN3        = 32'(WIN_L3_CYC);

    typedef enum logic [2:0] {IDLE, PICK, SHOW, CLEAR, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  target_q, target_d;
    logic [2:0]  prev_q, prev_d;
    logic [3:0]  tries_q, tries_d;
    logic [31:0] window_q, window_d;
    logic [31:0] win_cnt_q, win_cnt_d;
    logic [31:0] settle_q, settle_d;
    logic [31:0] sec_q, sec_d;
    logic [5:0]  timer_q, timer_d;
    logic [1:0]  level_q, level_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;

    logic        busy_now;
    logic        start_game;
    logic        lfsr_ok;
    logic        sensor_box;
    logic [2:0]  fallback;

    function automatic logic [1:0] level_of(input logic [5:0] t);
        logic [1:0] lvl;
        if (t < LVL2_AT)
            lvl = 2'd1;
        else if (t < LVL3_AT)
            lvl = 2'd2;
        else
            lvl = 2'd3;
        return lvl;
    endfunction

    function automatic logic [31:0] window_of(input logic [1:0] lvl);
        logic [31:0] w;
        case (lvl)
            2'd1:    w = WIN1;
            2'd2:    w = WIN2;
            default: w = WIN3;
        endcase
        return w;
    endfunction

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        prev_d     = prev_q;
        tries_d    = tries_q;
        window_d   = window_q;
        win_cnt_d  = win_cnt_q;
        settle_d   = settle_q;
        sec_d      = sec_q;
        timer_d    = timer_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        start_game = 1'b0;

        busy_now   = (state_q == PICK) || (state_q == SHOW) || (state_q == CLEAR);
        sensor_box = (sensor_input < NB);
        lfsr_ok    = (lfsr_value < NB) && (lfsr_value != prev_q);
        fallback   = ((prev_q + 3'd1) == NB) ? 3'd0 : prev_q + 3'd1;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_game = 1'b1;
                    tries_d    = 4'd0;
                    state_d    = PICK;
                end
            end
            PICK: begin
                // Window is frozen here so a level change mid-round never stretches or cuts it.
                if (tries_q == TRIES || lfsr_ok) begin
                    target_d  = (tries_q == TRIES) ? fallback : lfsr_value;
                    window_d  = window_of(level_q);
                    win_cnt_d = 32'd0;
                    state_d   = SHOW;
                end else begin
                    tries_d = tries_q + 4'd1;
                end
            end
            SHOW: begin
                if (sensor_input == target_q) begin
                    hit_d = 1'b1;
                end else if (sensor_box || win_cnt_q == window_q - 32'd1) begin
                    miss_d = 1'b1;
                end else begin
                    win_cnt_d = win_cnt_q + 32'd1;
                end
                if (hit_d || miss_d) begin
                    prev_d   = target_q;
                    settle_d = 32'd0;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                if (sensor_input != NO_HIT) begin
                    settle_d = 32'd0;
                end else if (settle_q == SETTLE_LAST) begin
                    settle_d = 32'd0;
                    tries_d  = 4'd0;
                    state_d  = PICK;
                end else begin
                    settle_d = settle_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_game) begin
            sec_d   = 32'd0;
            timer_d = 6'd0;
        end else if (busy_now && timer_q != GAME_END) begin
            if (sec_q == SEC_LAST) begin
                sec_d   = 32'd0;
                timer_d = timer_q + 6'd1;
            end else begin
                sec_d = sec_q + 32'd1;
            end
        end

        // Game end overrides any round transition; a strobe decided this cycle still goes out.
        if (busy_now && timer_q == GAME_END)
            state_d = DONE;

        level_d = level_of(timer_d);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            target_q  <= 3'd0;
            prev_q    <= 3'd0;
            tries_q   <= 4'd0;
            window_q  <= 32'd0;
            win_cnt_q <= 32'd0;
            settle_q  <= 32'd0;
            sec_q     <= 32'd0;
            timer_q   <= 6'd0;
            level_q   <= 2'd1;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            prev_q    <= prev_d;
            tries_q   <= tries_d;
            window_q  <= window_d;
            win_cnt_q <= win_cnt_d;
            settle_q  <= settle_d;
            sec_q     <= sec_d;
            timer_q   <= timer_d;
            level_q   <= level_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
        end
    end

`ifdef HIT_STREAK_EN
    logic [3:0] streak_q, streak_d;
    logic       bonus_q, bonus_d;

    always_comb begin
        streak_d = streak_q;
        bonus_d  = 1'b0;
        if (start_game || miss_d) begin
            streak_d = 4'd0;
        end else if (hit_d) begin
            streak_d = (streak_q == 4'd15) ? 4'd15 : streak_q + 4'd1;
            bonus_d  = (streak_d == 4'd5) || (streak_d == 4'd10) || (streak_d == 4'd15);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            streak_q <= 4'd0;
            bonus_q  <= 1'b0;
        end else begin
            streak_q <= streak_d;
            bonus_q  <= bonus_d;
        end
    end

    assign streak       = streak_q;
    assign streak_bonus = bonus_q;
`endif

    assign target_box       = target_q;
    assign target_valid     = (state_q == SHOW);
    assign hit_detected     = hit_q;
    assign miss_pulse       = miss_q;
    assign game_timer       = timer_q;
    assign difficulty_level = level_q;
    assign busy             = busy_now;
    assign game_over        = (state_q == DONE);

endmodule
